// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - register map, STATUS bit positions and FSM states for the SPI slave
package spi_slave_pkg;

    localparam logic [1:0] ADDR_RXDATA = 2'd0;
    localparam logic [1:0] ADDR_TXDATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int STAT_RX_FULL   = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_CS_ACTIVE = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rise/fall pulses on the synchronized level
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic CLK_I,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   fill_q;

    // Edges are suppressed until the chain holds only post-reset samples, so a
    // line that was already active across reset does not look like a new edge.
    always_ff @(posedge CLK_I) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = fill_q[SYNC_STAGES] & level & ~prev_q;
    assign fall  = fill_q[SYNC_STAGES] & ~level & prev_q;

endmodule

// File: rtl/spi_slave_wishbone.sv
// rtl/spi_slave_wishbone.sv - mode-0 SPI slave with byte-wide Wishbone register interface
module spi_slave_wishbone
    import spi_slave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_TX     = 8'h00
) (
    input  logic       CLK_I,
    input  logic       reset,
    input  logic       STB_I,
    input  logic       WE_I,
    input  logic [7:0] ADR_I,
    input  logic [7:0] DAT_I,
    output logic [7:0] DAT_O,
    output logic       ACK_O,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       irq
);

    spi_state_t state_q, state_d;

    logic       sck_level, sck_rise, sck_fall;
    logic       cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic       mosi_s;

    logic [7:0] shift_q;
    logic       rx_bit_q;
    logic [2:0] bit_cnt_q;
    logic       reload_q;
    logic [7:0] rx_data_q;
    logic [7:0] tx_hold_q;
    logic       rx_full_q, tx_full_q, overrun_q;

    logic       load_shift, shift_step, sample, frame_done;
    logic [7:0] frame_byte;
    logic       wb_acc, rd_rx, wr_tx, wr_stat;
    logic [1:0] adr;
    logic [7:0] status, rd_mux;
    logic       unused_bits;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .CLK_I (CLK_I),
        .reset (reset),
        .din   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .CLK_I (CLK_I),
        .reset (reset),
        .din   (cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // mosi gets the same depth as sck so the sampled bit lines up with the detected rise
    always_ff @(posedge CLK_I) begin
        if (reset) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    assign adr     = ADR_I[1:0];
    assign wb_acc  = STB_I & ~ACK_O;
    assign rd_rx   = wb_acc & ~WE_I & (adr == ADDR_RXDATA);
    assign wr_tx   = wb_acc & WE_I & (adr == ADDR_TXDATA);
    assign wr_stat = wb_acc & WE_I & (adr == ADDR_STATUS);

    assign unused_bits = &{1'b0, ADR_I[7:2], sck_level};

    always_comb begin
        status                 = 8'h00;
        status[STAT_RX_FULL]   = rx_full_q;
        status[STAT_TX_FULL]   = tx_full_q;
        status[STAT_OVERRUN]   = overrun_q;
        status[STAT_CS_ACTIVE] = ~cs_level;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (adr)
            ADDR_RXDATA: rd_mux = rx_data_q;
            ADDR_STATUS: rd_mux = status;
            ADDR_RSVD:   rd_mux = 8'h00;
            default:     rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        load_shift = 1'b0;
        shift_step = 1'b0;
        sample     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) state_d = LOAD;
            end
            LOAD: begin
                load_shift = 1'b1;
                state_d    = cs_rise ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else begin
                    sample = sck_rise;
                    if (sck_fall) begin
                        load_shift = reload_q;
                        shift_step = ~reload_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The incoming bit waits in rx_bit_q until the falling edge, so the outgoing
    // bit in shift_q[0] is not overwritten before it reaches shift_q[7].
    assign frame_done = sample & (bit_cnt_q == 3'd7);
    assign frame_byte = {shift_q[6:0], mosi_s};

    always_ff @(posedge CLK_I) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            rx_bit_q  <= 1'b0;
            bit_cnt_q <= 3'd0;
            reload_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_shift) begin
                shift_q   <= tx_full_q ? tx_hold_q : IDLE_TX;
                bit_cnt_q <= 3'd0;
                reload_q  <= 1'b0;
            end else if (shift_step) begin
                shift_q <= {shift_q[6:0], rx_bit_q};
            end
            if (sample) begin
                rx_bit_q  <= mosi_s;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) reload_q <= 1'b1;
            end
        end
    end

    // A write that lands on the consuming load still sets tx_full afterwards.
    always_ff @(posedge CLK_I) begin
        if (reset) begin
            tx_hold_q <= 8'h00;
            tx_full_q <= 1'b0;
        end else begin
            if (wr_tx) tx_hold_q <= DAT_I;
            if (wr_tx) begin
                tx_full_q <= 1'b1;
            end else if (load_shift && tx_full_q) begin
                tx_full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (reset) begin
            rx_data_q <= 8'h00;
            rx_full_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (frame_done && (!rx_full_q || rd_rx)) begin
                rx_data_q <= frame_byte;
                rx_full_q <= 1'b1;
            end else if (rd_rx) begin
                rx_full_q <= 1'b0;
            end
            if (frame_done && rx_full_q && !rd_rx) begin
                overrun_q <= 1'b1;
            end else if (wr_stat && DAT_I[STAT_OVERRUN]) begin
                overrun_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (reset) begin
            ACK_O <= 1'b0;
            DAT_O <= 8'h00;
        end else begin
            ACK_O <= wb_acc;
            DAT_O <= (wb_acc && !WE_I) ? rd_mux : 8'h00;
        end
    end

    assign miso = (state_q != IDLE) ? shift_q[7] : 1'b0;
    assign irq  = rx_full_q | overrun_q;

endmodule

// File: tb/tb_spi_slave_wishbone.sv
// tb/tb_spi_slave_wishbone.sv - directed bench for spi_slave_wishbone
module tb_spi_slave_wishbone;

    localparam int SYNC_STAGES = 2;

    logic       CLK_I = 1'b0;
    logic       reset = 1'b1;
    logic       STB_I = 1'b0;
    logic       WE_I  = 1'b0;
    logic [7:0] ADR_I = 8'h00;
    logic [7:0] DAT_I = 8'h00;
    logic [7:0] DAT_O;
    logic       ACK_O;
    logic       sck   = 1'b0;
    logic       cs    = 1'b1;
    logic       mosi  = 1'b0;
    logic       miso;
    logic       irq;

    int n_vec  = 0;
    int n_fail = 0;

    spi_slave_wishbone #(.SYNC_STAGES(SYNC_STAGES), .IDLE_TX(8'h00)) dut (
        .CLK_I (CLK_I),
        .reset (reset),
        .STB_I (STB_I),
        .WE_I  (WE_I),
        .ADR_I (ADR_I),
        .DAT_I (DAT_I),
        .DAT_O (DAT_O),
        .ACK_O (ACK_O),
        .sck   (sck),
        .cs    (cs),
        .mosi  (mosi),
        .miso  (miso),
        .irq   (irq)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    typedef struct {
        logic       do_tx;
        logic [7:0] tx;
        logic [7:0] mosi_byte;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        logic [7:0] exp_status;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                           output logic [7:0] rdat);
        int lat;
        lat  = 0;
        rdat = 8'hxx;
        STB_I = 1'b1;
        WE_I  = we;
        ADR_I = adr;
        DAT_I = wdat;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK_I);
            if (ACK_O) begin
                lat  = i;
                rdat = DAT_O;
                break;
            end
        end
        STB_I = 1'b0;
        WE_I  = 1'b0;
        @(negedge CLK_I);
        n_vec++;
        if (lat != 1 || ACK_O !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_ack adr=%02h: latency %0d, ack next cycle %b, expected latency 1 and ack 0",
                     adr, lat, ACK_O);
        end
    endtask

    task automatic rd_check(input string name, input logic [7:0] adr, input logic [7:0] exp);
        logic [7:0] d;
        wb_xfer(1'b0, adr, 8'h00, d);
        check(name, d, exp);
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [7:0] data);
        logic [7:0] d;
        wb_xfer(1'b1, adr, data, d);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        repeat (4) @(negedge CLK_I);
        m = miso;
        sck = 1'b1;
        repeat (4) @(negedge CLK_I);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
    endtask

    task automatic cs_start();
        cs = 1'b0;
        repeat (8) @(negedge CLK_I);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge CLK_I);
        cs = 1'b1;
        repeat (6) @(negedge CLK_I);
    endtask

    task automatic spi_frame(input logic [7:0] tx, output logic [7:0] rx);
        cs_start();
        spi_byte(tx, rx);
        cs_end();
    endtask

    vec_t       vecs[5];
    logic [7:0] got;
    logic       b;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h01};
        vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'h00, 8'h5A, 8'h01};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h01};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h01};
        vecs[4] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 8'h01};

        // reset state
        repeat (3) @(negedge CLK_I);
        check("reset_ack", {7'd0, ACK_O}, 8'h00);
        check("reset_dat", DAT_O, 8'h00);
        check("reset_miso", {7'd0, miso}, 8'h00);
        check("reset_irq", {7'd0, irq}, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge CLK_I);
        rd_check("reset_status", 8'h02, 8'h00);
        rd_check("reset_rxdata", 8'h00, 8'h00);
        rd_check("reg3_reads_zero", 8'h03, 8'h00);

        // table-driven single frames
        foreach (vecs[i]) begin
            if (vecs[i].do_tx) wb_write(8'h01, vecs[i].tx);
            spi_frame(vecs[i].mosi_byte, got);
            check($sformatf("v%0d_miso", i), got, vecs[i].exp_miso);
            rd_check($sformatf("v%0d_status", i), 8'h02, vecs[i].exp_status);
            check($sformatf("v%0d_irq", i), {7'd0, irq}, 8'h01);
            rd_check($sformatf("v%0d_rxdata", i), 8'h00, vecs[i].exp_rx);
            rd_check($sformatf("v%0d_status_after", i), 8'h02, 8'h00);
        end

        // back-to-back frames without draining RXDATA
        wb_write(8'h01, 8'h11);
        cs_start();
        spi_byte(8'hC3, got);
        check("b2b_miso0", got, 8'h11);
        spi_byte(8'h24, got);
        check("b2b_miso1_idle", got, 8'h00);
        cs_end();
        rd_check("b2b_status", 8'h02, 8'h05);
        rd_check("b2b_rxdata_first", 8'h00, 8'hC3);
        rd_check("b2b_status_overrun", 8'h02, 8'h04);
        check("b2b_irq_overrun", {7'd0, irq}, 8'h01);
        wb_write(8'h02, 8'h04);
        rd_check("b2b_status_cleared", 8'h02, 8'h00);
        check("b2b_irq_cleared", {7'd0, irq}, 8'h00);

        // partial frame aborted by cs, then a clean frame
        cs_start();
        rd_check("partial_cs_active", 8'h02, 8'h08);
        for (int i = 7; i >= 3; i--) spi_bit(1'b1, b);
        cs_end();
        rd_check("partial_status", 8'h02, 8'h00);
        spi_frame(8'h81, got);
        rd_check("after_partial_rx", 8'h00, 8'h81);

        // RXDATA read acknowledged in the same cycle the next frame completes
        spi_frame(8'h6E, got);
        cs_start();
        for (int i = 7; i >= 1; i--) spi_bit(got[0] ^ got[0] ^ ((8'h9D >> i) & 8'h01) != 0, b);
        mosi = 1'b1;
        repeat (4) @(negedge CLK_I);
        sck = 1'b1;
        repeat (SYNC_STAGES) @(negedge CLK_I);
        wb_xfer(1'b0, 8'h00, 8'h00, got);
        check("coinc_read_old", got, 8'h6E);
        sck = 1'b0;
        cs_end();
        rd_check("coinc_status", 8'h02, 8'h01);
        rd_check("coinc_rx_new", 8'h00, 8'h9D);

        // TXDATA write landing on the LOAD cycle
        cs = 1'b0;
        repeat (SYNC_STAGES + 1) @(negedge CLK_I);
        wb_write(8'h01, 8'h96);
        rd_check("txload_status", 8'h02, 8'h0A);
        spi_byte(8'h12, got);
        check("txload_miso_first", got, 8'h00);
        spi_byte(8'h34, got);
        check("txload_miso_second", got, 8'h96);
        cs_end();
        rd_check("txload_end_status", 8'h02, 8'h05);
        rd_check("txload_rx", 8'h00, 8'h12);
        wb_write(8'h02, 8'h04);

        // reset in the middle of a frame
        spi_frame(8'h77, got);
        wb_write(8'h01, 8'hFF);
        cs_start();
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        check("pre_reset_miso", {7'd0, miso}, 8'h01);
        check("pre_reset_irq", {7'd0, irq}, 8'h01);
        reset = 1'b1;
        @(negedge CLK_I);
        check("midrst_ack", {7'd0, ACK_O}, 8'h00);
        check("midrst_dat", DAT_O, 8'h00);
        check("midrst_miso", {7'd0, miso}, 8'h00);
        check("midrst_irq", {7'd0, irq}, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge CLK_I);
        spi_byte(8'hAA, got);
        repeat (4) @(negedge CLK_I);
        rd_check("midrst_no_frame", 8'h02, 8'h08);
        cs_end();
        spi_frame(8'h42, got);
        rd_check("midrst_next_status", 8'h02, 8'h01);
        rd_check("midrst_next_rx", 8'h00, 8'h42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
